write_back_unit: RTL and testbench

//   Producer side of the register-bank write port. Accepts completed MEM-stage results and formats load data.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/load_formatter.sv | 34 +++
 rtl/write_back_unit.sv | 143 ++++++++++++++
 tb/tb_write_back_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back unit.
package wb_pkg;

   localparam int unsigned WB_DATA_W        = 32;
   localparam int unsigned LINK_REG_DEFAULT = 31;
   localparam logic [4:0]  REG_ZERO         = 5'd0;

   // Load access size; encoding 3 is reserved and behaves as a word.
   typedef enum logic [1:0] {
      LD_BYTE = 2'd0,
      LD_HALF = 2'd1,
      LD_WORD = 2'd2
   } ld_size_t;

   // One queued write-back result.
   typedef struct packed {
      logic                 we;
      logic [4:0]           rd;
      logic [WB_DATA_W-1:0] data;
      logic                 mis;
   } wb_entry_t;

endpackage

// File: rtl/load_formatter.sv
// Load data formatter: lane selection, sign/zero extension and misalignment detection.
module load_formatter
   import wb_pkg::*;
#(
   parameter int unsigned DATA_W = WB_DATA_W
)(
   input  logic [DATA_W-1:0] in_mem,
   input  logic [1:0]        ld_size,
   input  logic              ld_unsigned,
   input  logic [1:0]        addr_lo,
   output logic [DATA_W-1:0] data,
   output logic              mis
);

   logic [7:0]  byte_lane;
   logic [15:0] half_lane;

   // Select the addressed lane, extend it, and flag misaligned half/word accesses.
   always_comb begin
      byte_lane = in_mem[{addr_lo, 3'b000} +: 8];
      half_lane = in_mem[{addr_lo[1], 4'b0000} +: 16];
      data      = in_mem;
      mis       = 1'b0;
      case (ld_size)
         LD_BYTE: data = {{(DATA_W-8){~ld_unsigned & byte_lane[7]}}, byte_lane};
         LD_HALF: begin
            data = {{(DATA_W-16){~ld_unsigned & half_lane[15]}}, half_lane};
            mis  = addr_lo[0];
         end
         default: mis = (addr_lo != 2'b00);
      endcase
   end

endmodule

// File: rtl/write_back_unit.sv
// Write-back unit: formats MEM-stage results, queues them and drives the register-bank write port.
// Optional macro WB_FORWARD_EN adds fwd_valid/fwd_rd/fwd_data (youngest queued writing entry).
// The queue entry type comes from wb_pkg, so DATA_W must stay equal to WB_DATA_W.
module write_back_unit
   import wb_pkg::*;
#(
   parameter int unsigned DATA_W    = WB_DATA_W,
   parameter int unsigned DEPTH     = 2,
   parameter int unsigned PC_OFFSET = 4,
   parameter int unsigned LINK_REG  = LINK_REG_DEFAULT
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_reg_write,
   input  logic              in_mem_to_reg,
   input  logic              in_jal,
   input  logic [4:0]        in_rd,
   input  logic [DATA_W-1:0] in_pc,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_mem,
   input  logic [1:0]        in_ld_size,
   input  logic              in_ld_unsigned,
   input  logic [1:0]        in_addr_lo,
   input  logic              rf_ready,
   output logic              rf_we,
   output logic [4:0]        rf_rd,
   output logic [DATA_W-1:0] rf_data,
   output logic              err_misalign,
   output logic [31:0]       retired_cnt
`ifdef WB_FORWARD_EN
   ,
   output logic              fwd_valid,
   output logic [4:0]        fwd_rd,
   output logic [DATA_W-1:0] fwd_data
`endif
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   wb_entry_t         queue [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic              push;
   logic              pop;
   logic [DATA_W-1:0] fmt_data;
   logic              fmt_mis;
   wb_entry_t         new_entry;
   wb_entry_t         head;

   load_formatter #(.DATA_W(DATA_W)) u_load_formatter (
      .in_mem      (in_mem),
      .ld_size     (in_ld_size),
      .ld_unsigned (in_ld_unsigned),
      .addr_lo     (in_addr_lo),
      .data        (fmt_data),
      .mis         (fmt_mis)
   );

   assign in_ready = (count != CNT_W'(DEPTH));
   assign push     = in_valid & in_ready;
   assign pop      = (count != '0) & rf_ready;
   assign head     = queue[rd_ptr];

   // Build the entry to enqueue; jal overrides, then $zero suppresses the write.
   always_comb begin
      new_entry = '0;
      if (in_jal) begin
         new_entry.we   = 1'b1;
         new_entry.rd   = 5'(LINK_REG);
         new_entry.data = in_pc + DATA_W'(PC_OFFSET);
      end else begin
         new_entry.rd = in_rd;
         if (in_mem_to_reg) begin
            new_entry.data = fmt_data;
            new_entry.mis  = fmt_mis;
         end else begin
            new_entry.data = in_alu;
         end
         new_entry.we = in_reg_write & ~new_entry.mis;
      end
      if (new_entry.rd == REG_ZERO) new_entry.we = 1'b0;
   end

   // Present the queue head to the bank; all zero while empty.
   always_comb begin
      rf_we   = 1'b0;
      rf_rd   = '0;
      rf_data = '0;
      if (count != '0) begin
         rf_we   = head.we & rf_ready;
         rf_rd   = head.rd;
         rf_data = head.data;
      end
   end

   // Queue storage; contents are only meaningful below count, so no reset.
   always_ff @(posedge clk) begin
      if (push) queue[wr_ptr] <= new_entry;
   end

   // Pointers, occupancy, retire counter and misalignment pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         retired_cnt  <= '0;
         err_misalign <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr      <= rd_ptr + 1'b1;
            retired_cnt <= retired_cnt + 32'd1;
         end
         count        <= count + CNT_W'(push) - CNT_W'(pop);
         err_misalign <= pop & head.mis;
      end
   end

`ifdef WB_FORWARD_EN
   // Scan oldest to youngest so the youngest writing entry wins.
   always_comb begin
      logic [PTR_W-1:0] idx;
      fwd_valid = 1'b0;
      fwd_rd    = '0;
      fwd_data  = '0;
      idx       = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         idx = rd_ptr + PTR_W'(i);
         if ((CNT_W'(i) < count) && queue[idx].we) begin
            fwd_valid = 1'b1;
            fwd_rd    = queue[idx].rd;
            fwd_data  = queue[idx].data;
         end
      end
   end
`endif

endmodule

// File: tb/tb_write_back_unit.sv
// Scoreboard testbench for write_back_unit: directed cases plus randomized traffic.
module tb_write_back_unit;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_reg_write, in_mem_to_reg, in_jal;
   logic [4:0]  in_rd;
   logic [31:0] in_pc, in_alu, in_mem;
   logic [1:0]  in_ld_size, in_addr_lo;
   logic        in_ld_unsigned;
   logic        rf_ready, rf_we, err_misalign;
   logic [4:0]  rf_rd;
   logic [31:0] rf_data, retired_cnt;
`ifdef WB_FORWARD_EN
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
`endif

   write_back_unit #(.DATA_W(32), .DEPTH(DEPTH), .PC_OFFSET(4), .LINK_REG(31)) dut (
      .clk            (clk),
      .reset          (reset),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_reg_write   (in_reg_write),
      .in_mem_to_reg  (in_mem_to_reg),
      .in_jal         (in_jal),
      .in_rd          (in_rd),
      .in_pc          (in_pc),
      .in_alu         (in_alu),
      .in_mem         (in_mem),
      .in_ld_size     (in_ld_size),
      .in_ld_unsigned (in_ld_unsigned),
      .in_addr_lo     (in_addr_lo),
      .rf_ready       (rf_ready),
      .rf_we          (rf_we),
      .rf_rd          (rf_rd),
      .rf_data        (rf_data),
      .err_misalign   (err_misalign),
      .retired_cnt    (retired_cnt)
`ifdef WB_FORWARD_EN
      ,
      .fwd_valid      (fwd_valid),
      .fwd_rd         (fwd_rd),
      .fwd_data       (fwd_data)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          we;
      logic [4:0]  rd;
      logic [31:0] data;
      bit          mis;
   } exp_t;

   exp_t        sbq[$];
   int unsigned exp_ret;
   bit          exp_err;
   bit          started;
   int          tests;
   int          fails;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Reference formatting from the architectural rules, using the current inputs.
   function automatic exp_t ref_fmt();
      exp_t        e;
      logic [31:0] v;
      e.we   = 1'b0;
      e.rd   = in_rd;
      e.data = in_alu;
      e.mis  = 1'b0;
      if (in_jal) begin
         e.we   = 1'b1;
         e.rd   = 5'd31;
         e.data = in_pc + 32'd4;
      end else begin
         if (in_mem_to_reg) begin
            if (in_ld_size == 2'd0) begin
               v = (in_mem >> (8 * in_addr_lo)) & 32'h0000_00FF;
               if (!in_ld_unsigned && v[7]) v = v | 32'hFFFF_FF00;
               e.data = v;
            end else if (in_ld_size == 2'd1) begin
               v = (in_mem >> (16 * in_addr_lo[1])) & 32'h0000_FFFF;
               if (!in_ld_unsigned && v[15]) v = v | 32'hFFFF_0000;
               e.data = v;
               e.mis  = in_addr_lo[0];
            end else begin
               e.data = in_mem;
               e.mis  = (in_addr_lo != 2'd0);
            end
         end
         e.we = in_reg_write && !e.mis;
      end
      if (e.rd == 5'd0) e.we = 1'b0;
      return e;
   endfunction

   task automatic set_in(input bit v, input bit rw, input bit m2r, input bit j,
                         input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] mem, input logic [1:0] sz, input bit u,
                         input logic [1:0] lo);
      in_valid       = v;
      in_reg_write   = rw;
      in_mem_to_reg  = m2r;
      in_jal         = j;
      in_rd          = rd;
      in_pc          = pc;
      in_alu         = alu;
      in_mem         = mem;
      in_ld_size     = sz;
      in_ld_unsigned = u;
      in_addr_lo     = lo;
   endtask

   // Advance one clock; an accepted input is recorded in the scoreboard at the edge.
   task automatic step();
      bit   acc;
      exp_t e;
      acc = in_valid && in_ready && !reset;
      e   = ref_fmt();
      @(posedge clk);
      if (acc) sbq.push_back(e);
      #1;
   endtask

   task automatic one_load(input string name, input logic [1:0] sz, input bit u,
                           input logic [1:0] lo, input logic [31:0] req);
      set_in(1, 1, 1, 0, 5'd9, 0, 0, 32'h80FF_7F01, sz, u, lo);
      step();
      chk(name, rf_data, req);
      in_valid = 1'b0;
      step();
   endtask

   // Monitor: compare the presented head against the scoreboard on the falling edge.
   always @(negedge clk) begin
      if (started && !reset) begin
         chk("in_ready", in_ready, (sbq.size() < DEPTH));
         chk("retired_cnt", retired_cnt, exp_ret);
         chk("err_misalign", err_misalign, exp_err);
         exp_err = 1'b0;
         if (sbq.size() > 0) begin
            chk("rf_we", rf_we, sbq[0].we && rf_ready);
            chk("rf_rd", rf_rd, sbq[0].rd);
            chk("rf_data", rf_data, sbq[0].data);
            if (rf_ready) begin
               exp_err = sbq[0].mis;
               exp_ret++;
               void'(sbq.pop_front());
            end
         end else begin
            chk("empty_we", rf_we, 0);
            chk("empty_rd", rf_rd, 0);
            chk("empty_data", rf_data, 0);
         end
      end
   end

   initial begin
      tests   = 0;
      fails   = 0;
      exp_ret = 0;
      exp_err = 1'b0;
      started = 1'b0;
      reset   = 1'b1;
      rf_ready = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_we", rf_we, 0);
      chk("rst_rd", rf_rd, 0);
      chk("rst_data", rf_data, 0);
      chk("rst_err", err_misalign, 0);
      chk("rst_retired", retired_cnt, 0);
      reset   = 1'b0;
      started = 1'b1;

      // ALU write
      rf_ready = 1'b1;
      set_in(1, 1, 0, 0, 5'd5, 0, 32'h1234, 0, 2, 0, 0);
      step();
      chk("t1_we", rf_we, 1);
      chk("t1_rd", rf_rd, 5);
      chk("t1_data", rf_data, 32'h1234);
      in_valid = 1'b0;
      step();
      chk("t1_retired", retired_cnt, 1);

      // Load formatting
      one_load("t2_lb",  2'd0, 0, 2'd3, 32'hFFFF_FF80);
      one_load("t2_lbu", 2'd0, 1, 2'd3, 32'h0000_0080);
      one_load("t2_lh",  2'd1, 0, 2'd2, 32'hFFFF_80FF);

      // jal link and $zero suppression
      set_in(1, 0, 0, 1, 5'd7, 32'h0040_0010, 32'hDEAD_BEEF, 0, 2, 0, 0);
      step();
      chk("t3_jal_rd", rf_rd, 31);
      chk("t3_jal_data", rf_data, 32'h0040_0014);
      chk("t3_jal_we", rf_we, 1);
      in_valid = 1'b0;
      step();
      set_in(1, 1, 0, 0, 5'd0, 0, 32'hABCD_0001, 0, 2, 0, 0);
      step();
      chk("t3_zero_we", rf_we, 0);
      in_valid = 1'b0;
      step();
      chk("t3_retired", retired_cnt, 6);

      // Backpressure: fill, hold a third, then drain with overlap
      rf_ready = 1'b0;
      set_in(1, 1, 0, 0, 5'd10, 0, 32'hA0, 0, 2, 0, 0);
      step();
      set_in(1, 1, 0, 0, 5'd11, 0, 32'hA1, 0, 2, 0, 0);
      step();
      chk("t4_full", in_ready, 0);
      set_in(1, 1, 0, 0, 5'd12, 0, 32'hA2, 0, 2, 0, 0);
      step();
      chk("t4_held", in_ready, 0);
      chk("t4_head", rf_rd, 10);
      rf_ready = 1'b1;
      step();
      chk("t4_head2", rf_rd, 11);
      step();
      chk("t4_overlap_ready", in_ready, 1);
      chk("t4_head3", rf_rd, 12);
      in_valid = 1'b0;
      step();
      chk("t4_empty", rf_we, 0);

      // Misaligned word load
      set_in(1, 1, 1, 0, 5'd13, 0, 0, 32'h1122_3344, 2, 0, 2'd2);
      step();
      chk("t5_we", rf_we, 0);
      in_valid = 1'b0;
      step();
      chk("t5_err_pulse", err_misalign, 1);
      step();
      chk("t5_err_clear", err_misalign, 0);

      // Asynchronous reset between edges with two entries queued
      rf_ready = 1'b0;
      set_in(1, 1, 0, 0, 5'd14, 0, 32'hB0, 0, 2, 0, 0);
      step();
      set_in(1, 1, 0, 0, 5'd15, 0, 32'hB1, 0, 2, 0, 0);
      step();
      in_valid = 1'b0;
      rf_ready = 1'b1;
      #1;
      chk("t6_pre_we", rf_we, 1);
      #1;
      reset = 1'b1;
      #1;
      chk("t6_we", rf_we, 0);
      chk("t6_rd", rf_rd, 0);
      chk("t6_data", rf_data, 0);
      chk("t6_ready", in_ready, 1);
      chk("t6_retired", retired_cnt, 0);
      sbq.delete();
      exp_ret = 0;
      exp_err = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      step();
      chk("t6_after_we", rf_we, 0);
      chk("t6_after_ready", in_ready, 1);

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         set_in($urandom_range(0, 9) < 7, $urandom_range(0, 7) != 0,
                $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
                $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)));
         rf_ready = ($urandom_range(0, 9) < 6);
         step();
      end
      in_valid = 1'b0;
      rf_ready = 1'b1;
      repeat (4) step();
      chk("drain_ready", in_ready, 1);
      chk("drain_we", rf_we, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
